// File: rtl/tcp_pkg.sv
// tcp_pkg: FSM encoding, protocol constants and checksum fold shared by the TCP transmit path
package tcp_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FOLD = 3'd2;
  localparam logic [2:0] S_HEAD = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  localparam logic [7:0] TCP_PROT       = 8'd6;
  localparam int         HEAD_WORDS_MIN = 5;
  localparam logic [7:0] OPT_KIND_MSS   = 8'd2;
  localparam logic [7:0] OPT_LEN_MSS    = 8'd4;

  localparam logic [1:0] BE_4 = 2'b00;
  localparam logic [1:0] BE_3 = 2'b11;
  localparam logic [1:0] BE_2 = 2'b10;
  localparam logic [1:0] BE_1 = 2'b01;

  // end-around-carry fold of a 32-bit one's-complement accumulator down to 16 bits
  function automatic logic [15:0] csum_fold(input logic [31:0] a);
    logic [16:0] s;
    s = {1'b0, a[31:16]} + {1'b0, a[15:0]};
    s = {1'b0, s[15:0]} + {16'd0, s[16]};
    return s[15:0];
  endfunction

  // keeps the valid leading bytes of the final payload word; rem = len mod 4
  function automatic logic [31:0] tail_mask(input logic [1:0] rem);
    return rem == 2'd1 ? 32'hFF00_0000 :
           rem == 2'd2 ? 32'hFFFF_0000 :
           rem == 2'd3 ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
  endfunction

endpackage

// File: rtl/tcp_tx_pay_ram.sv
// tcp_tx_pay_ram: 2^AW x 32 payload buffer with one write port and one registered read port
module tcp_tx_pay_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  // write port plus registered read; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/tcp_tx_segmenter.sv
// tcp_tx_segmenter: buffers a payload, computes the TCP checksum and streams the segment to the IP layer.
// Build option TCP_TX_MSS_OPT_EN: SYN segments carry a 4-byte MSS option (header of 6 words).
module tcp_tx_segmenter
  import tcp_pkg::*;
#(
  parameter int PAY_AW = 8
`ifdef TCP_TX_MSS_OPT_EN
  ,
  parameter logic [15:0] MSS = 16'd1460
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  input  logic [15:0] src_port_i,
  input  logic [15:0] dst_port_i,
  input  logic [31:0] seq_num_i,
  input  logic [31:0] ack_num_i,
  input  logic [5:0]  tcp_flags_i,
  input  logic [15:0] tcp_window_i,
  input  logic [15:0] pay_len_i,
  input  logic        tx_start_i,
  input  logic        pay_we_i,
  input  logic [31:0] pay_data_i,
  input  logic        tx_rdy_i,
  output logic        busy_o,
  output logic        len_err_o,
  output logic        ip_op_st_o,
  output logic        ip_op_o,
  output logic        ip_op_end_o,
  output logic [31:0] ip_data_o,
  output logic [1:0]  ip_data_be_o,
  output logic [15:0] ip_len_o,
  output logic [7:0]  ip_prot_o,
  output logic [31:0] ip_dst_o
);

  localparam int CAP_BYTES = 4 << PAY_AW;
  localparam int CW        = PAY_AW + 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, nw_q;
  logic [2:0]    hidx_q, hidx_d;
  logic [31:0]   acc_q, acc_d;
  logic [15:0]   csum_q, csum_d;
  logic          len_err_q;
  logic [1:0]    rem_q;
  logic [3:0]    hlen_q;
  logic [15:0]   tlen_q, sport_q, dport_q, win_q;
  logic [31:0]   seq_q, ack_q, dst_q;
  logic [5:0]    flags_q;

  logic          start_req, too_big, start_ok;
  logic [3:0]    hlen_s;
  logic [15:0]   tlen_s;
  logic [31:0]   opt_sum_s, hsum_s;
  logic [CW-1:0] nw_s;
  logic          we, load_last, hlast, dlast, fire;
  logic [31:0]   wdata, ram_q, hword;

  assign start_req = state_q == S_IDLE && tx_start_i;
  assign too_big   = 17'(pay_len_i) > 17'(CAP_BYTES);
  assign start_ok  = start_req && !too_big;
  assign nw_s      = CW'((17'(pay_len_i) + 17'd3) >> 2);

`ifdef TCP_TX_MSS_OPT_EN
  assign hlen_s    = tcp_flags_i[1] ? 4'(HEAD_WORDS_MIN + 1) : 4'(HEAD_WORDS_MIN);
  assign opt_sum_s = tcp_flags_i[1] ? 32'({OPT_KIND_MSS, OPT_LEN_MSS}) + 32'(MSS) : 32'd0;
`else
  assign hlen_s    = 4'(HEAD_WORDS_MIN);
  assign opt_sum_s = 32'd0;
`endif

  assign tlen_s = {10'd0, hlen_s, 2'b00} + pay_len_i;
  // pseudo-header plus every header half-word; the checksum and urgent-pointer fields count as zero
  assign hsum_s = 32'(src_ip_i[31:16]) + 32'(src_ip_i[15:0]) + 32'(dst_ip_i[31:16]) + 32'(dst_ip_i[15:0])
                + 32'(TCP_PROT) + 32'(tlen_s) + 32'(src_port_i) + 32'(dst_port_i)
                + 32'(seq_num_i[31:16]) + 32'(seq_num_i[15:0]) + 32'(ack_num_i[31:16]) + 32'(ack_num_i[15:0])
                + 32'({hlen_s, 6'b0, tcp_flags_i}) + 32'(tcp_window_i) + opt_sum_s;

  assign we        = state_q == S_LOAD && pay_we_i;
  assign load_last = cnt_q == nw_q - CW'(1);
  assign wdata     = pay_data_i & (load_last ? tail_mask(rem_q) : 32'hFFFF_FFFF);
  assign hlast     = hidx_q == 3'(hlen_q - 4'd1);
  assign dlast     = idx_q == nw_q - CW'(1);
  assign fire      = ip_op_o && tx_rdy_i;

  // sequencing: load/sum payload, fold, then walk header words and buffered payload words
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hidx_d  = hidx_q;
    acc_d   = acc_q;
    csum_d  = csum_q;
    if (state_q == S_IDLE) begin
      if (start_ok) begin
        state_d = pay_len_i == 16'd0 ? S_FOLD : S_LOAD;
        cnt_d   = '0;
        acc_d   = hsum_s;
      end
    end else if (state_q == S_LOAD) begin
      if (we) begin
        cnt_d   = cnt_q + CW'(1);
        acc_d   = acc_q + 32'(wdata[31:16]) + 32'(wdata[15:0]);
        state_d = load_last ? S_FOLD : S_LOAD;
      end
    end else if (state_q == S_FOLD) begin
      csum_d  = ~csum_fold(acc_q);
      hidx_d  = '0;
      idx_d   = '0;
      state_d = S_HEAD;
    end else if (state_q == S_HEAD) begin
      if (fire) begin
        hidx_d  = hidx_q + 3'd1;
        state_d = !hlast ? S_HEAD : nw_q == '0 ? S_IDLE : S_DATA;
      end
    end else if (state_q == S_DATA) begin
      if (fire) begin
        idx_d   = idx_q + CW'(1);
        state_d = dlast ? S_IDLE : S_DATA;
      end
    end
  end

  // control state; a reset drops any segment in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      hidx_q    <= '0;
      acc_q     <= '0;
      csum_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hidx_q    <= hidx_d;
      acc_q     <= acc_d;
      csum_q    <= csum_d;
      len_err_q <= start_req && too_big;
    end
  end

  // segment fields captured on an accepted start and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sport_q <= '0;
      dport_q <= '0;
      seq_q   <= '0;
      ack_q   <= '0;
      flags_q <= '0;
      win_q   <= '0;
      dst_q   <= '0;
      tlen_q  <= '0;
      hlen_q  <= '0;
      rem_q   <= '0;
      nw_q    <= '0;
    end else if (start_ok) begin
      sport_q <= src_port_i;
      dport_q <= dst_port_i;
      seq_q   <= seq_num_i;
      ack_q   <= ack_num_i;
      flags_q <= tcp_flags_i;
      win_q   <= tcp_window_i;
      dst_q   <= dst_ip_i;
      tlen_q  <= tlen_s;
      hlen_q  <= hlen_s;
      rem_q   <= pay_len_i[1:0];
      nw_q    <= nw_s;
    end
  end

  // read address tracks the word on show so ram_q holds it across stalls; word 0 is prefetched during HEAD
  tcp_tx_pay_ram #(.AW(PAY_AW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (cnt_q[PAY_AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (idx_d[PAY_AW-1:0]),
    .rdata_o (ram_q)
  );

  assign hword = hidx_q == 3'd0 ? {sport_q, dport_q} :
                 hidx_q == 3'd1 ? seq_q :
                 hidx_q == 3'd2 ? ack_q :
                 hidx_q == 3'd3 ? {hlen_q, 6'b0, flags_q, win_q} :
                 hidx_q == 3'd4 ? {csum_q, 16'h0000} :
`ifdef TCP_TX_MSS_OPT_EN
                 hidx_q == 3'd5 ? {OPT_KIND_MSS, OPT_LEN_MSS, MSS} :
`endif
                 32'd0;

  assign busy_o       = state_q != S_IDLE;
  assign len_err_o    = len_err_q;
  assign ip_op_o      = state_q == S_HEAD || state_q == S_DATA;
  assign ip_op_st_o   = state_q == S_HEAD && hidx_q == 3'd0;
  assign ip_op_end_o  = (state_q == S_HEAD && hlast && nw_q == '0) || (state_q == S_DATA && dlast);
  assign ip_data_o    = state_q == S_HEAD ? hword : state_q == S_DATA ? ram_q : 32'd0;
  assign ip_data_be_o = !(state_q == S_DATA && dlast) ? BE_4 :
                        rem_q == 2'd1 ? BE_1 :
                        rem_q == 2'd2 ? BE_2 :
                        rem_q == 2'd3 ? BE_3 : BE_4;
  assign ip_len_o     = tlen_q;
  assign ip_prot_o    = TCP_PROT;
  assign ip_dst_o     = dst_q;

endmodule

// File: tb/tb_tcp_tx_segmenter.sv
// tb_tcp_tx_segmenter: randomized segments checked against a byte-level TCP reference model
module tb_tcp_tx_segmenter;

`ifdef TCP_TX_MSS_OPT_EN
  localparam bit OPT = 1'b1;
`else
  localparam bit OPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src_ip_i = '0, dst_ip_i = '0, seq_num_i = '0, ack_num_i = '0, pay_data_i = '0;
  logic [15:0] src_port_i = '0, dst_port_i = '0, tcp_window_i = '0, pay_len_i = '0;
  logic [5:0]  tcp_flags_i = '0;
  logic        tx_start_i = 1'b0, pay_we_i = 1'b0, tx_rdy_i = 1'b0;
  logic        busy_o, len_err_o, ip_op_st_o, ip_op_o, ip_op_end_o;
  logic [31:0] ip_data_o, ip_dst_o;
  logic [1:0]  ip_data_be_o;
  logic [15:0] ip_len_o;
  logic [7:0]  ip_prot_o;

  always #5 clk = ~clk;

  tcp_tx_segmenter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_ip_i     (src_ip_i),
    .dst_ip_i     (dst_ip_i),
    .src_port_i   (src_port_i),
    .dst_port_i   (dst_port_i),
    .seq_num_i    (seq_num_i),
    .ack_num_i    (ack_num_i),
    .tcp_flags_i  (tcp_flags_i),
    .tcp_window_i (tcp_window_i),
    .pay_len_i    (pay_len_i),
    .tx_start_i   (tx_start_i),
    .pay_we_i     (pay_we_i),
    .pay_data_i   (pay_data_i),
    .tx_rdy_i     (tx_rdy_i),
    .busy_o       (busy_o),
    .len_err_o    (len_err_o),
    .ip_op_st_o   (ip_op_st_o),
    .ip_op_o      (ip_op_o),
    .ip_op_end_o  (ip_op_end_o),
    .ip_data_o    (ip_data_o),
    .ip_data_be_o (ip_data_be_o),
    .ip_len_o     (ip_len_o),
    .ip_prot_o    (ip_prot_o),
    .ip_dst_o     (ip_dst_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] f_src, f_dst, f_seq, f_ack;
  logic [15:0] f_sp, f_dp, f_win;
  logic [5:0]  f_fl;
  logic [31:0] pw [256];
  byte unsigned mb[$];
  logic [31:0] exp_w[$], got_w[$], ref_w[$];
  int exp_be, exp_hl;
  logic [31:0] got_len, got_be;

  function automatic void push_n(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mb.push_back(8'(v >> (8 * i)));
  endfunction

  // segment as a byte string in wire order, checksum over pseudo-header + bytes
  task automatic build_exp(input int len);
    int unsigned sum;
    int hl, tl;
    logic [15:0] cs;
    hl = (OPT && f_fl[1]) ? 6 : 5;
    tl = hl * 4 + len;
    mb.delete();
    push_n(32'(f_sp), 2); push_n(32'(f_dp), 2); push_n(f_seq, 4); push_n(f_ack, 4);
    push_n(32'(hl << 4), 1); push_n(32'(f_fl), 1); push_n(32'(f_win), 2); push_n(0, 4);
    if (hl == 6) begin push_n(2, 1); push_n(4, 1); push_n(1460, 2); end
    for (int i = 0; i < len; i++) push_n(pw[i / 4] >> (8 * (3 - i % 4)), 1);
    sum = 32'(f_src[31:16]) + 32'(f_src[15:0]) + 32'(f_dst[31:16]) + 32'(f_dst[15:0]) + 6 + 32'(tl);
    for (int i = 0; i < mb.size(); i += 2) begin
      sum += 32'(mb[i]) << 8;
      if (i + 1 < mb.size()) sum += 32'(mb[i + 1]);
    end
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    mb[16] = cs[15:8];
    mb[17] = cs[7:0];
    while (mb.size() % 4 != 0) mb.push_back(8'd0);
    exp_w.delete();
    for (int i = 0; i < mb.size(); i += 4) exp_w.push_back({mb[i], mb[i + 1], mb[i + 2], mb[i + 3]});
    exp_be = len % 4;
    exp_hl = hl;
  endtask

  task automatic rand_fields();
    f_src = $urandom; f_dst = $urandom; f_seq = $urandom; f_ack = $urandom;
    f_sp = 16'($urandom); f_dp = 16'($urandom); f_win = 16'($urandom); f_fl = 6'($urandom);
  endtask

  task automatic gen_pay(input int len);
    for (int i = 0; i < (len + 3) / 4; i++) pw[i] = $urandom;
  endtask

  task automatic run_seg(input int len, input int rdy_pct, input bit inject, input int abort_at);
    int nw, k, cyc;
    bit held;
    logic [31:0] hw;
    nw = (len + 3) / 4;
    build_exp(len);
    got_w.delete();
    @(negedge clk);
    src_ip_i = f_src; dst_ip_i = f_dst; src_port_i = f_sp; dst_port_i = f_dp;
    seq_num_i = f_seq; ack_num_i = f_ack; tcp_flags_i = f_fl; tcp_window_i = f_win;
    pay_len_i = 16'(len); tx_start_i = 1'b1;
    @(negedge clk);
    tx_start_i = 1'b0;
    for (int i = 0; i < nw; i++) begin
      while (rdy_pct < 100 && $urandom_range(0, 3) == 0) @(negedge clk);
      pay_we_i = 1'b1; pay_data_i = pw[i];
      @(negedge clk);
      pay_we_i = 1'b0;
    end
    if (rdy_pct == 100) begin
      check("lat_fold", 32'(ip_op_o), 0);
      @(negedge clk);
      check("lat_head", 32'(ip_op_o), 1);
    end
    k = 0; cyc = 0; held = 1'b0; hw = '0;
    while (k < exp_w.size() && cyc < 4000) begin
      tx_start_i = 1'b0; pay_we_i = 1'b0;
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_op", 32'(ip_op_o), 0);
        check("rst_st", 32'(ip_op_st_o), 0);
        check("rst_end", 32'(ip_op_end_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_data", ip_data_o, 0);
        check("rst_len", 32'(ip_len_o), 0);
        check("rst_dst", ip_dst_o, 0);
        tx_rdy_i = 1'b0;
        return;
      end
      if (held) begin
        check("hold_op", 32'(ip_op_o), 1);
        check("hold_data", ip_data_o, hw);
      end
      tx_rdy_i = $urandom_range(1, 100) <= rdy_pct;
      if (ip_op_o && tx_rdy_i) begin
        got_w.push_back(ip_data_o);
        check($sformatf("word%0d", k), ip_data_o, exp_w[k]);
        check("st", 32'(ip_op_st_o), 32'(k == 0));
        check("end", 32'(ip_op_end_o), 32'(k == exp_w.size() - 1));
        check("be", 32'(ip_data_be_o), (k == exp_w.size() - 1) ? 32'(exp_be) : 0);
        check("len", 32'(ip_len_o), 32'(exp_hl * 4 + len));
        check("dst", ip_dst_o, f_dst);
        if (k == 0) got_len = 32'(ip_len_o);
        if (k == exp_w.size() - 1) got_be = 32'(ip_data_be_o);
        k++;
      end
      held = ip_op_o && !tx_rdy_i;
      hw = ip_data_o;
      if (inject && k == exp_hl + 1) begin
        tx_start_i = 1'b1; pay_len_i = 16'd8; pay_we_i = 1'b1; pay_data_i = 32'hDEADBEEF;
      end
      @(negedge clk);
      cyc++;
    end
    tx_rdy_i = 1'b0; tx_start_i = 1'b0; pay_we_i = 1'b0;
    check("words_done", 32'(k), 32'(exp_w.size()));
    check("idle_busy", 32'(busy_o), 0);
    @(negedge clk);
    check("idle_op", 32'(ip_op_o), 0);
  endtask

  initial begin
    logic [31:0] lit[$];
    int lit_len, nerr, nop, nbusy;
    int lens[6];
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_op", 32'(ip_op_o), 0);
    check("reset_data", ip_data_o, 0);
    check("reset_err", 32'(len_err_o), 0);
    check("reset_len", 32'(ip_len_o), 0);
    check("reset_dst", ip_dst_o, 0);
    check("reset_be", 32'(ip_data_be_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    f_src = 32'h0A000001; f_dst = 32'h0A000002; f_sp = 16'h1234; f_dp = 16'h0050;
    f_seq = 32'd1; f_ack = 32'd0; f_fl = 6'h02; f_win = 16'hFFFF;
    run_seg(0, 100, 1'b0, -1);
`ifdef TCP_TX_MSS_OPT_EN
    lit = {32'h12340050, 32'h1, 32'h0, 32'h6002FFFF, 32'h719F0000, 32'h020405B4};
    lit_len = 24;
`else
    lit = {32'h12340050, 32'h1, 32'h0, 32'h5002FFFF, 32'h895B0000};
    lit_len = 20;
`endif
    check("syn_count", 32'(got_w.size()), 32'(lit.size()));
    foreach (lit[i]) check($sformatf("syn_word%0d", i), got_w[i], lit[i]);
    check("syn_iplen", got_len, 32'(lit_len));
    check("syn_be", got_be, 0);

    f_fl = 6'h18;
    pw[0] = 32'hAABBCCDD;
    run_seg(3, 100, 1'b0, -1);
    check("p3_word5", got_w[5], 32'hAABBCC00);
    check("p3_be", got_be, 32'h3);
    check("p3_iplen", got_len, 32'd23);

    rand_fields();
    gen_pay(100);
    run_seg(100, 100, 1'b0, -1);
    ref_w = got_w;
    run_seg(100, 40, 1'b0, -1);
    check("bp_count", 32'(got_w.size()), 32'(ref_w.size()));
    foreach (ref_w[i]) check($sformatf("bp_same%0d", i), got_w[i], ref_w[i]);

    @(negedge clk);
    tx_start_i = 1'b1; pay_len_i = 16'd1025;
    @(negedge clk);
    tx_start_i = 1'b0;
    nerr = 0; nop = 0; nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      nerr += int'(len_err_o); nop += int'(ip_op_o); nbusy += int'(busy_o);
      @(negedge clk);
    end
    check("lenerr_pulses", 32'(nerr), 1);
    check("lenerr_busy", 32'(nbusy), 0);
    check("lenerr_op", 32'(nop), 0);

    rand_fields();
    gen_pay(40);
    run_seg(40, 100, 1'b1, -1);
    repeat (3) @(negedge clk);
    check("inject_busy", 32'(busy_o), 0);

    lens = '{1024, 4, 5, 6, 7, 0};
    lens[5] = $urandom_range(1, 1024);
    foreach (lens[i]) begin
      rand_fields();
      gen_pay(lens[i]);
      run_seg(lens[i], $urandom_range(30, 100), 1'b0, -1);
    end

    rand_fields();
    gen_pay(200);
    run_seg(200, 100, 1'b0, 8);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_fields();
    gen_pay(60);
    run_seg(60, 70, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcp_tx_segmenter.md
Name: tcp_tx_segmenter

Overview:
- Transmit-side TCP segment builder; the mirror of the TCP receive parser.
- Accepts header fields and a 32-bit payload stream from the application/connection logic, and buffers the payload in an internal word RAM.
- Computes the full TCP checksum (pseudo-header, header and payload), then emits the segment as a 32-bit word stream to the IP transmit layer.
- The output stream uses the same start/op/end/byte-enable framing the receive path consumes.

Parameters:
- PAY_AW, 8: payload buffer address width; capacity 2^PAY_AW words (1024 bytes).
- MSS, 16'd1460: MSS value advertised when the option is compiled in.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_ip_i  in  32  source IP, for the pseudo-header
- dst_ip_i  in  32  destination IP, for the pseudo-header and passed to the IP layer
- src_port_i  in  16  TCP source port
- dst_port_i  in  16  TCP destination port
- seq_num_i  in  32  sequence number
- ack_num_i  in  32  acknowledge number
- tcp_flags_i  in  6  URG..FIN flags
- tcp_window_i  in  16  window size
- pay_len_i  in  16  payload length in bytes
- tx_start_i  in  1  one-cycle request; all fields above are valid in this cycle
- pay_we_i  in  1  payload word write strobe
- pay_data_i  in  32  payload word, big-endian, first byte in [31:24]
- tx_rdy_i  in  1  IP layer accepts the current output word
- busy_o  out  1  segment in progress
- len_err_o  out  1  one-cycle pulse: start rejected because pay_len_i exceeds capacity
- ip_op_st_o  out  1  first word of segment
- ip_op_o  out  1  output word valid
- ip_op_end_o  out  1  last word of segment
- ip_data_o  out  32  segment word
- ip_data_be_o  out  2  last-word bytes: 00=4, 11=3, 10=2, 01=1
- ip_len_o  out  16  TCP segment length in bytes (header + payload)
- ip_prot_o  out  8  constant 8'd6
- ip_dst_o  out  32  latched destination IP

Behaviour:
- Reset: rst_n low clears all state asynchronously. State returns to IDLE, all outputs go to 0, and the payload buffer contents are don't-care. A reset mid-segment aborts the segment with no partial end marker.
- State machine: IDLE -> LOAD -> FOLD -> HEAD -> DATA -> IDLE.
- IDLE:
  - tx_start_i latches all fields; busy_o=1 from the next cycle.
  - If pay_len_i > 4*2^PAY_AW: pulse len_err_o, stay in IDLE.
  - If pay_len_i == 0: go directly to FOLD.
- LOAD:
  - Each pay_we_i stores one word, increments the word count and adds the data to the 32-bit checksum accumulator.
  - On the last word (count == ceil(len/4)), bytes beyond the length are zeroed before both storing and summing.
  - After the last word, go to FOLD.
  - pay_we_i outside LOAD is ignored. tx_start_i while busy is ignored.
- Checksum accumulator:
  - Initialised at start to the pseudo-header sum: src hi + src lo + dst hi + dst lo + 16'h0006 + tcp_len.
  - tcp_len = head_len*4 + pay_len; head_len = 5, or 6 with the option.
  - Header 16-bit halves are added at start with the checksum field = 0, plus option words if present.
  - Payload adds [31:16] + [15:0] per word.
- FOLD (one cycle): fold the carry twice into 16 bits, then invert; the result is the checksum. 16'h0000 is emitted as is.
- HEAD: emit header words 0..head_len-1 in order:
  - {sport,dport}
  - seq
  - ack
  - {head_len,6'b0,flags,window}
  - {csum,16'h0000}
  - [option word]
- DATA: read buffer words 0..ceil(len/4)-1. The buffer is synchronous-read, so prefetch one word so no bubble is inserted between the HEAD and DATA phases.
- Output handshake:
  - A word is held stable on ip_data_o with ip_op_o=1 until tx_rdy_i=1; it advances on a cycle with ip_op_o & tx_rdy_i.
  - ip_op_st_o accompanies word 0. ip_op_end_o accompanies the final word (the last header word if pay_len==0).
  - ip_data_be_o is nonzero only with ip_op_end_o in DATA; it is 00 otherwise.
  - ip_len_o and ip_dst_o are stable from HEAD until return to IDLE.
- Completion: after the end word is accepted, busy_o=0 in the next cycle, and a new tx_start_i is accepted that cycle.
- Latency: tx_start_i to first ip_op_o is ceil(len/4) load cycles + 2 (latch, FOLD).

Optional Feature:
- Macro: TCP_TX_MSS_OPT_EN.
- Defined: head_len=6 and one option word {8'd2,8'd4,MSS} is emitted after the checksum word, only when the SYN flag (tcp_flags_i[1]) is set; otherwise head_len=5. The option word is included in the checksum.
- Undefined: head_len is always 5; no option logic is built.

Decomposition:
- Package tcp_pkg holds:
  - state enum
  - TCP_PROT=8'd6
  - HEAD_WORDS_MIN=5
  - option kind/length constants
  - BE encodings
  - checksum fold function (32->16)
- Sub-module tcp_tx_pay_ram: single-port-write / single-port-read synchronous RAM, 2^PAY_AW x 32.

Test Plan:
- SYN, no payload:
  - Stimulus: src 0x0A000001, dst 0x0A000002, sport 0x1234, dport 0x0050, seq 1, ack 0, flags 0x02, win 0xFFFF, option undefined, tx_rdy_i=1.
  - Required: 5 words 0x12340050, 0x00000001, 0x00000000, 0x5002FFFF, 0x895B0000; op_end on word 4; ip_len 20; be 00.
- Same segment with TCP_TX_MSS_OPT_EN: word 3 = 0x6002FFFF, word 5 = 0x020405B4, ip_len 24, end on word 5; checksum recomputed and verified by a reference model.
- Payload of 3 bytes, pay_data_i=0xAABBCCDD: DATA word 0xAABBCCDD masked to 0xAABBCC00; be 11 with op_end on word 5; ip_len 23; checksum matches model.
- Backpressure: random tx_rdy_i on a 100-byte payload; every word is held stable while not accepted; output sequence identical to the tx_rdy_i=1 run.
- pay_len_i=1025: len_err_o pulses once, busy_o stays 0, no output. A tx_start_i during DATA is ignored and the current segment completes.
- rst_n asserted mid-DATA: all outputs 0 immediately; a following segment is emitted correctly.
